// File: rtl/reset_sequencer.sv
// Reset sequencer for the readout datapath.
// Qualifies a synchronized PLL lock, then releases NUM_STAGES reset outputs
// one at a time, lowest index first, STAGE_DELAY cycles apart. Lock loss or
// a software request re-asserts every stage. All outputs are registered.
module reset_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int STAGE_DELAY     = 16,
  parameter int LOCK_FILTER     = 8,
  parameter int SOFT_RST_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_released,
  output logic                  busy,
  output logic [7:0]            lock_lost_cnt
);

  // Counter widths hold their terminal count with a spare bit of headroom.
  localparam int LOCK_W = $clog2(LOCK_FILTER) + 1;
  localparam int DLY_W  = $clog2(STAGE_DELAY) + 1;
  localparam int IDX_W  = $clog2(NUM_STAGES) + 1;
  localparam int SOFT_W = $clog2(SOFT_RST_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_e;

  // Two-flop synchronizer for the asynchronous PLL lock.
  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic                  locked_s;

  state_e                state_q, state_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [DLY_W-1:0]      delay_cnt_q, delay_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SOFT_W-1:0]     soft_cnt_q, soft_cnt_d;
  logic [7:0]            lost_cnt_q, lost_cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_rel_q, all_rel_d;
  logic                  busy_q, busy_d;
  logic                  lock_loss;

  assign locked_s = sync2_q;

  // Synchronize pll_locked into the clk domain; cleared by rst so the lock
  // filter always starts from an unlocked view.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; a blocking '=' here would collapse
    // the two synchronizer stages into one.
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Lock loss only counts once sequencing has started; a low lock in HOLD is
  // simply part of qualification.
  assign lock_loss = (state_q != ST_HOLD) && !locked_s;

  // Next-state logic: priority is lock loss > soft request > sequencing.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    delay_cnt_d = delay_cnt_q;
    idx_d       = idx_q;
    soft_cnt_d  = soft_cnt_q;
    lost_cnt_d  = lost_cnt_q;

    unique case (state_q)
      ST_HOLD: begin
        delay_cnt_d = '0;
        idx_d       = '0;
        soft_cnt_d  = '0;
        if (locked_s) begin
          if (lock_cnt_q == LOCK_W'(LOCK_FILTER - 1)) begin
            state_d    = ST_RELEASE;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end else begin
          lock_cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (soft_rst_req) begin
          state_d     = ST_SOFT;
          soft_cnt_d  = '0;
          delay_cnt_d = '0;
          idx_d       = '0;
          lock_cnt_d  = '0;
        end else if (delay_cnt_q == DLY_W'(STAGE_DELAY - 1)) begin
          delay_cnt_d = '0;
          idx_d       = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = ST_RUN;
          end
        end else begin
          delay_cnt_d = delay_cnt_q + DLY_W'(1);
        end
      end

      ST_RUN: begin
        if (soft_rst_req) begin
          state_d     = ST_SOFT;
          soft_cnt_d  = '0;
          delay_cnt_d = '0;
          idx_d       = '0;
          lock_cnt_d  = '0;
        end
      end

      ST_SOFT: begin
        // Further requests are ignored so the hold time never stretches.
        if (soft_cnt_q == SOFT_W'(SOFT_RST_CYCLES - 1)) begin
          state_d    = ST_HOLD;
          soft_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          soft_cnt_d = soft_cnt_q + SOFT_W'(1);
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Lock loss overrides everything above and forces full re-qualification.
    if (lock_loss) begin
      state_d     = ST_HOLD;
      lock_cnt_d  = '0;
      delay_cnt_d = '0;
      idx_d       = '0;
      soft_cnt_d  = '0;
      if (lost_cnt_q != 8'hFF) begin
        lost_cnt_d = lost_cnt_q + 8'd1;
      end
    end
  end

  // Output decode: stage i stays asserted while i >= idx, which makes the
  // release pattern a thermometer that can never release out of order.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_rst_d[i] = (IDX_W'(i) >= idx_d);
    end
    all_rel_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      lock_cnt_q  <= '0;
      delay_cnt_q <= '0;
      idx_q       <= '0;
      soft_cnt_q  <= '0;
      lost_cnt_q  <= '0;
      stage_rst_q <= '1;
      all_rel_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      idx_q       <= idx_d;
      soft_cnt_q  <= soft_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      stage_rst_q <= stage_rst_d;
      all_rel_q   <= all_rel_d;
      busy_q      <= busy_d;
    end
  end

  assign stage_rst     = stage_rst_q;
  assign all_released  = all_rel_q;
  assign busy          = busy_q;
  assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. A cycle-level reference model
// tracks phase and elapsed time; expected outputs are derived arithmetically
// from elapsed time rather than from per-stage counters.
module tb_reset_sequencer;

  localparam int NS              = 4;
  localparam int STAGE_DELAY     = 16;
  localparam int LOCK_FILTER     = 8;
  localparam int SOFT_RST_CYCLES = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          soft_rst_req;
  logic [NS-1:0] stage_rst;
  logic          all_released;
  logic          busy;
  logic [7:0]    lock_lost_cnt;
  logic [13:0]   act;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = holding, 1 = sequencing (release or run),
  // 2 = software hold. m_t counts edges since entering the mode.
  int m_mode, m_t, m_run, m_lost;
  bit m_s1, m_s2;

  logic [NS-1:0] hist [0:200];
  logic          ahist [0:200];

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .STAGE_DELAY    (STAGE_DELAY),
    .LOCK_FILTER    (LOCK_FILTER),
    .SOFT_RST_CYCLES(SOFT_RST_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .stage_rst    (stage_rst),
    .all_released (all_released),
    .busy         (busy),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  assign act = {stage_rst, all_released, busy, lock_lost_cnt};

  // Advance the model by one clock edge using the inputs present at the edge.
  function automatic void model_edge();
    if (rst) begin
      m_mode = 0; m_t = 0; m_run = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (m_mode == 0) begin
        if (m_s2) begin
          m_run++;
          if (m_run == LOCK_FILTER) begin
            m_mode = 1; m_t = 0; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (!m_s2) begin
        m_mode = 0; m_run = 0;
        if (m_lost < 255) m_lost++;
      end else if (m_mode == 1 && soft_rst_req) begin
        m_mode = 2; m_t = 0;
      end else begin
        m_t++;
        if (m_mode == 2 && m_t == SOFT_RST_CYCLES) begin
          m_mode = 0; m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
  endfunction

  // Expected {stage_rst, all_released, busy, lock_lost_cnt}.
  function automatic logic [13:0] exp_vec();
    logic [NS-1:0] st;
    logic          ar;
    int            rel;
    st = '1;
    ar = 1'b0;
    if (m_mode == 1) begin
      rel = m_t / STAGE_DELAY;
      if (rel > NS) rel = NS;
      st = st << rel;
      ar = (rel == NS);
    end
    return {st, ar, ~ar, 8'(m_lost)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; soft_rst_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (act !== {4'hF, 1'b0, 1'b1, 8'd0}) begin
        failures++;
        $display("FAIL reset_const cyc=%0d got=%h exp=%h", c, act, {4'hF, 1'b0, 1'b1, 8'd0});
      end
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_defaults();
    rst = 1'b0; pll_locked = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      step();
      hist[c] = stage_rst; ahist[c] = all_released;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL defaults cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    checks++;
    if ({hist[25], hist[26], hist[42], hist[58], hist[73], hist[74]} !==
        {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1000, 4'b0000}) begin
      failures++;
      $display("FAIL defaults_timing got=%h exp=%h",
               {hist[25], hist[26], hist[42], hist[58], hist[73], hist[74]},
               {4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1000, 4'b0000});
    end
    checks++;
    if ({ahist[73], ahist[74]} !== 2'b01) begin
      failures++;
      $display("FAIL defaults_all_released got=%b exp=01", {ahist[73], ahist[74]});
    end
  endtask

  task automatic test_glitch_lock();
    int first;
    rst = 1'b1; pll_locked = 1'b0;
    step();
    rst = 1'b0;
    first = -1;
    for (int c = 1; c <= 100; c++) begin
      pll_locked = (c != 6);
      step();
      if (first < 0 && stage_rst !== 4'hF) first = c;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    checks++;
    if (first != 32) begin
      failures++;
      $display("FAIL glitch_first_release got=%0d exp=32", first);
    end
    checks++;
    if (lock_lost_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_lost_cnt got=%0d exp=0", lock_lost_cnt);
    end
  endtask

  task automatic test_lock_loss();
    for (int d = 1; d <= 100; d++) begin
      pll_locked = (d > 4);
      step();
      hist[d] = stage_rst; ahist[d] = all_released;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL lock_loss cyc=%0d got=%h exp=%h", d, act, exp_vec());
      end
      if (d == 3) begin
        checks++;
        if ({stage_rst, busy, lock_lost_cnt} !== {4'hF, 1'b1, 8'd1}) begin
          failures++;
          $display("FAIL lock_loss_drop got=%h exp=%h", {stage_rst, busy, lock_lost_cnt}, {4'hF, 1'b1, 8'd1});
        end
      end
    end
    checks++;
    if ({hist[2], hist[29], hist[30], ahist[77], ahist[78]} !== {4'b0000, 4'b1111, 4'b1110, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lock_loss_relock got=%h exp=%h",
               {hist[2], hist[29], hist[30], ahist[77], ahist[78]}, {4'b0000, 4'b1111, 4'b1110, 1'b0, 1'b1});
    end
  endtask

  task automatic test_soft_reset();
    pll_locked = 1'b1;
    for (int s = 1; s <= 120; s++) begin
      soft_rst_req = (s == 1 || s == 11);
      step();
      hist[s] = stage_rst; ahist[s] = all_released;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL soft cyc=%0d got=%h exp=%h", s, act, exp_vec());
      end
    end
    soft_rst_req = 1'b0;
    checks++;
    if ({hist[1], hist[56], hist[57], ahist[104], ahist[105]} !== {4'b1111, 4'b1111, 4'b1110, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL soft_timing got=%h exp=%h",
               {hist[1], hist[56], hist[57], ahist[104], ahist[105]}, {4'b1111, 4'b1111, 4'b1110, 1'b0, 1'b1});
    end
  endtask

  task automatic test_rst_mid_sequence();
    for (int d = 1; d <= 140; d++) begin
      pll_locked = !(d >= 1 && d <= 4);
      rst = (d == 50);
      step();
      hist[d] = stage_rst;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h", d, act, exp_vec());
      end
      if (d == 50) begin
        checks++;
        if ({stage_rst, lock_lost_cnt} !== {4'hF, 8'd0}) begin
          failures++;
          $display("FAIL rst_mid_clear got=%h exp=%h", {stage_rst, lock_lost_cnt}, {4'hF, 8'd0});
        end
      end
    end
    rst = 1'b0;
    checks++;
    if ({hist[49], hist[75], hist[76]} !== {4'b1100, 4'b1111, 4'b1110}) begin
      failures++;
      $display("FAIL rst_mid_restart got=%h exp=%h", {hist[49], hist[75], hist[76]}, {4'b1100, 4'b1111, 4'b1110});
    end
  endtask

  task automatic test_loss_and_soft();
    for (int x = 1; x <= 100; x++) begin
      pll_locked = (x > 4);
      soft_rst_req = (x == 3);
      step();
      hist[x] = stage_rst;
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL loss_soft cyc=%0d got=%h exp=%h", x, act, exp_vec());
      end
      if (x == 3) begin
        checks++;
        if ({stage_rst, lock_lost_cnt} !== {4'hF, 8'd1}) begin
          failures++;
          $display("FAIL loss_soft_count got=%h exp=%h", {stage_rst, lock_lost_cnt}, {4'hF, 8'd1});
        end
      end
    end
    soft_rst_req = 1'b0;
    checks++;
    if ({hist[29], hist[30]} !== {4'b1111, 4'b1110}) begin
      failures++;
      $display("FAIL loss_soft_relock got=%h exp=%h", {hist[29], hist[30]}, {4'b1111, 4'b1110});
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; pll_locked = 1'b0;
    step();
    rst = 1'b0;
    for (int e = 0; e < 300; e++) begin
      for (int p = 0; p < 15; p++) begin
        pll_locked = (p < 12);
        step();
        checks++;
        if (act !== exp_vec()) begin
          failures++;
          $display("FAIL saturation ev=%0d cyc=%0d got=%h exp=%h", e, p, act, exp_vec());
        end
      end
    end
    checks++;
    if (lock_lost_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturation_final got=%0d exp=255", lock_lost_cnt);
    end
  endtask

  task automatic test_random();
    int drop;
    drop = 0;
    rst = 1'b1;
    step();
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(999) == 0);
      soft_rst_req = ($urandom_range(149) == 0);
      if (drop > 0) begin
        drop--;
        pll_locked = 1'b0;
      end else if ($urandom_range(299) == 0) begin
        drop = $urandom_range(5);
        pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
      end
      step();
      checks++;
      if (act !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    rst = 1'b0; soft_rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
    m_mode = 0; m_t = 0; m_run = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
    test_reset();
    test_defaults();
    test_glitch_lock();
    test_lock_loss();
    test_soft_reset();
    test_rst_mid_sequence();
    test_loss_and_soft();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumes the synchronized system reset and produces ordered, per-subsystem reset releases for the readout datapath. It holds all domains in reset until the PLL lock is stable, then releases the stages one at a time at fixed spacing. It re-asserts every stage on lock loss or on a software reset request. It sits directly downstream of the reset synchronizer, in the same clock domain.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (2..8)
STAGE_DELAY, 16, cycles between consecutive stage releases (>=2)
LOCK_FILTER, 8, consecutive cycles the synchronized lock must be high before sequencing starts (>=1)
SOFT_RST_CYCLES, 32, cycles all stages are held in SOFT state (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pll_locked  in  1  PLL lock; asynchronous to clk, 2-flop synchronized internally (ASYNC_REG), reset to 0
soft_rst_req  in  1  single-cycle software reset request, synchronous to clk
stage_rst  out  NUM_STAGES  per-stage reset, active-high; bit 0 is released first
all_released  out  1  high only in RUN
busy  out  1  high in any state other than RUN
lock_lost_cnt  out  8  count of lock-loss events, saturating at 255

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- All outputs are registered.
- While rst=1 or on the cycle after rst:
  - state=HOLD, stage_rst=all ones, all_released=0, busy=1, lock_lost_cnt=0.
  - Sync flops, lock filter counter, delay counter and stage index are all 0.
- Signal names:
  - locked_s = second synchronizer flop.
  - Lock loss = locked_s=0 while in RELEASE, RUN or SOFT.
- HOLD state:
  - stage_rst is all ones.
  - lock_cnt increments on each edge with locked_s=1 and clears to 0 when locked_s=0.
  - On the LOCK_FILTER-th consecutive edge with locked_s=1: go to RELEASE, delay_cnt=0, idx=0.
  - soft_rst_req is ignored.
- RELEASE state:
  - delay_cnt counts 0..STAGE_DELAY-1.
  - When delay_cnt reaches STAGE_DELAY-1: clear stage_rst[idx], increment idx, wrap delay_cnt to 0.
  - Stage k falls exactly (k+1)*STAGE_DELAY cycles after RELEASE entry.
  - When the last bit clears, go to RUN on the same edge; all_released rises on that same edge and busy falls.
  - Released stages stay released; the unreleased stages stay asserted.
- RUN state:
  - stage_rst=0, all_released=1.
- SOFT state:
  - Entered from RELEASE or RUN when soft_rst_req=1.
  - On the next edge stage_rst becomes all ones, all_released=0.
  - Holds for SOFT_RST_CYCLES cycles, then goes to HOLD with lock_cnt=0, which forces full lock re-qualification.
  - A soft_rst_req received during SOFT is ignored; the hold count does not restart.
- Lock loss:
  - In RELEASE, RUN or SOFT: next edge goes to HOLD with stage_rst all ones and lock_cnt=0.
  - lock_lost_cnt increments by 1 and saturates at 255.
  - Lock low while already in HOLD is not counted.
- Priority on the same edge: rst > lock loss > soft_rst_req > sequencing.
  - Lock loss together with soft_rst_req goes to HOLD and counts the event.
- A glitchy lock (high for fewer than LOCK_FILTER cycles) never leaves HOLD.
- rst mid-sequence restarts cleanly from HOLD; no stage may release early.
- stage_rst must never show a higher-index bit cleared while a lower-index bit is set.
- Counter widths: $clog2 of the maximum count plus 1, with no overflow for the legal parameter ranges.

Test Plan:
1. Defaults. rst released, pll_locked held high → RELEASE entered 8 edges after locked_s first high. Relative to RELEASE entry, stage_rst goes 4'b1110 at +16, 4'b1100 at +32, 4'b1000 at +48, 4'b0000 at +64. all_released rises at +64.
2. pll_locked pulses high for 5 cycles, low for 1, then steady high → no release until 8 consecutive high samples; first release is 16 cycles after that. lock_lost_cnt stays 0.
3. In RUN, pll_locked drops → next edge after locked_s=0: stage_rst=4'b1111, busy=1, lock_lost_cnt=1. On relock the full sequence repeats with identical timing.
4. In RUN, soft_rst_req pulses → stage_rst=4'b1111 for 32 cycles, then HOLD, 8-cycle lock qualification, then the normal release sequence. A second pulse during SOFT does not extend the hold.
5. During RELEASE after stage 1 is released (4'b1100), pull rst high for 1 cycle → stage_rst=4'b1111 and lock_lost_cnt=0; the sequence restarts from stage 0.
6. Force 300 lock-loss events → lock_lost_cnt saturates at 255. Lock loss and soft_rst_req on the same cycle → HOLD, counter increments.
